// File: rtl/avalon_burst_responder_pkg.sv
// Shared types and constants for the Avalon-MM burst responder.
// State encoding, bus widths and burst-count clamping.
package avalon_burst_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_WRITE_BURST = 2'd1,
    ST_READ_BURST  = 2'd2
  } state_t;

  localparam int DATA_W     = 64;
  localparam int BE_W       = 8;
  localparam int WORD_SHIFT = 3;

  // A count of zero means a single beat.
  function automatic logic [7:0] clamp_count(
    input logic [7:0] c,
    input logic [7:0] max_c
  );
    logic [7:0] r;
    r = c;
    if (c == 8'd0)
      r = 8'd1;
    else if (c > max_c)
      r = max_c;
    return r;
  endfunction

endpackage

// File: rtl/sdp_ram_be.sv
// Simple dual-port RAM: byte-enabled write port, registered read port.
// Contents are never reset.
module sdp_ram_be
  import avalon_burst_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  i_clock,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [BE_W-1:0]       i_be,
  input  logic [DATA_W-1:0]     i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_W-1:0]     o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_WIDTH];

  always_ff @(posedge i_clock) begin
    if (i_we) begin
      for (int b = 0; b < BE_W; b++) begin
        if (i_be[b])
          r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
    if (i_re)
      o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/avalon_burst_responder.sv
// Avalon-MM burst responder backed by on-chip RAM.
// Accepts single/burst writes and reads; read data returns two edges later.
module avalon_burst_responder
  import avalon_burst_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int MAX_BURST  = 128
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic [31:0] i_address,
  input  logic [7:0]  i_be,
  input  logic        i_read_req,
  input  logic        i_write_req,
  input  logic        i_burst_begin,
  input  logic [7:0]  i_burst_count,
  input  logic [63:0] i_write_data,
  output logic [63:0] o_read_data,
  output logic        o_read_data_valid,
  output logic        o_wait_request
);

  localparam logic [7:0] MAX_C = 8'(MAX_BURST);
  localparam logic [ADDR_WIDTH-1:0] A_ONE = ADDR_WIDTH'(1);

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_remain;
  logic                  r_rd_pend;

  logic [ADDR_WIDTH-1:0] w_word;
  logic [7:0]            w_count;
  logic                  w_idle;
  logic                  w_cmd_wr;
  logic                  w_cmd_rd;
  logic                  w_wbeat;
  logic                  w_we;
  logic                  w_re;
  logic                  w_last;
  logic [ADDR_WIDTH-1:0] w_waddr;
  logic [DATA_W-1:0]     w_rdata;
  logic                  w_unused_addr;

  assign w_word  = i_address[ADDR_WIDTH+2:WORD_SHIFT];
  assign w_count = clamp_count(i_burst_count, MAX_C);
  assign w_unused_addr =
    ^{i_address[31:ADDR_WIDTH+3], i_address[2:0]};

  assign w_idle   = (r_state == ST_IDLE);
  assign w_cmd_wr = w_idle & i_burst_begin & i_write_req;
  // Write wins over a simultaneous read.
  assign w_cmd_rd = w_idle & i_burst_begin & i_read_req
                  & ~i_write_req;
  assign w_wbeat  = (r_state == ST_WRITE_BURST) & i_write_req;
  assign w_we     = w_cmd_wr | w_wbeat;
  assign w_waddr  = w_idle ? w_word : r_addr;
  assign w_re     = (r_state == ST_READ_BURST);
  assign w_last   = (r_remain == 8'd1);

  assign o_wait_request = w_re;

  sdp_ram_be #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .i_clock (i_clock),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_be    (i_be),
    .i_wdata (i_write_data),
    .i_re    (w_re),
    .i_raddr (r_addr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state           <= ST_IDLE;
      r_addr            <= '0;
      r_remain          <= '0;
      r_rd_pend         <= 1'b0;
      o_read_data       <= '0;
      o_read_data_valid <= 1'b0;
    end else begin
      r_rd_pend         <= w_re;
      o_read_data_valid <= r_rd_pend;
      if (r_rd_pend)
        o_read_data <= w_rdata;

      unique case (r_state)
        ST_IDLE: begin
          if (w_cmd_wr) begin
            if (w_count != 8'd1) begin
              r_addr   <= w_word + A_ONE;
              r_remain <= w_count - 8'd1;
              r_state  <= ST_WRITE_BURST;
            end
          end else if (w_cmd_rd) begin
            r_addr   <= w_word;
            r_remain <= w_count;
            r_state  <= ST_READ_BURST;
          end
        end
        ST_WRITE_BURST: begin
          if (i_write_req) begin
            r_addr   <= r_addr + A_ONE;
            r_remain <= r_remain - 8'd1;
            if (w_last)
              r_state <= ST_IDLE;
          end
        end
        ST_READ_BURST: begin
          r_addr   <= r_addr + A_ONE;
          r_remain <= r_remain - 8'd1;
          if (w_last)
            r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_burst_responder.sv
// Bench for avalon_burst_responder: two instances (1024- and 16-word)
// share stimulus and are checked against a word-array memory model.
module tb_avalon_burst_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [7:0]  be;
  logic        rd;
  logic        wr;
  logic        bb;
  logic [7:0]  cnt;
  logic [63:0] wd;

  logic [63:0] rd10, rd4;
  logic        rv10, rv4;
  logic        wt10, wt4;

  int nchk = 0;
  int nfail = 0;

  logic [63:0] m10 [1024];
  logic [63:0] m4  [16];
  logic [63:0] dq  [$];

  always #5 clk = ~clk;

  avalon_burst_responder #(
    .ADDR_WIDTH(10),
    .MAX_BURST (128)
  ) dut10 (
    .i_clock          (clk),
    .i_reset          (rst),
    .i_address        (addr),
    .i_be             (be),
    .i_read_req       (rd),
    .i_write_req      (wr),
    .i_burst_begin    (bb),
    .i_burst_count    (cnt),
    .i_write_data     (wd),
    .o_read_data      (rd10),
    .o_read_data_valid(rv10),
    .o_wait_request   (wt10)
  );

  avalon_burst_responder #(
    .ADDR_WIDTH(4),
    .MAX_BURST (128)
  ) dut4 (
    .i_clock          (clk),
    .i_reset          (rst),
    .i_address        (addr),
    .i_be             (be),
    .i_read_req       (rd),
    .i_write_req      (wr),
    .i_burst_begin    (bb),
    .i_burst_count    (cnt),
    .i_write_data     (wd),
    .o_read_data      (rd4),
    .o_read_data_valid(rv4),
    .o_wait_request   (wt4)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int eff(input logic [7:0] c);
    if (c == 8'd0) return 1;
    if (c > 8'd128) return 128;
    return int'(c);
  endfunction

  task automatic model_wr(input int w,
                          input logic [63:0] d,
                          input logic [7:0] e);
    for (int b = 0; b < 8; b++) begin
      if (e[b]) begin
        m10[w % 1024][b*8 +: 8] = d[b*8 +: 8];
        m4[w % 16][b*8 +: 8]    = d[b*8 +: 8];
      end
    end
  endtask

  task automatic idle_in();
    rd = 0; wr = 0; bb = 0;
    be = 0; wd = 0; cnt = 0; addr = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wait_low(input string tag);
    chk({tag, "_wait10"}, wt10, 1'b0);
    chk({tag, "_wait4"}, wt4, 1'b0);
  endtask

  // Write burst using data from dq; optional single stall before beat
  // stall_at, optional random stalls.
  task automatic wr_burst(input logic [31:0] a,
                          input logic [7:0]  c,
                          input logic [7:0]  bem,
                          input int          stall_at,
                          input bit          rnd_stall);
    int n, base, k;
    bit stalled;
    n = eff(c);
    base = int'(a[31:3]);
    stalled = 0;
    addr = a; cnt = c; bb = 1; wr = 1; be = bem; wd = dq[0];
    step();
    model_wr(base, dq[0], bem);
    bb = 0; addr = 0; cnt = 0;
    chk_wait_low("wr_cmd");
    k = 1;
    while (k < n) begin
      if ((k == stall_at && !stalled) ||
          (rnd_stall && $urandom_range(3) == 0)) begin
        stalled = 1;
        wr = 0;
        step();
        chk_wait_low("wr_stall");
      end else begin
        wr = 1; wd = dq[k];
        step();
        model_wr(base + k, dq[k], bem);
        chk_wait_low("wr_beat");
        k++;
      end
    end
    idle_in();
  endtask

  task automatic rd_burst(input logic [31:0] a, input logic [7:0] c);
    int n, base;
    bit ev;
    n = eff(c);
    base = int'(a[31:3]);
    rd = 1; bb = 1; addr = a; cnt = c;
    step();
    idle_in();
    for (int j = 0; j < n + 3; j++) begin
      ev = (j >= 2) && (j < n + 2);
      chk("rd_wait10", wt10, (j < n));
      chk("rd_wait4", wt4, (j < n));
      chk("rd_valid10", rv10, ev);
      chk("rd_valid4", rv4, ev);
      if (ev) begin
        chk("rd_data10", rd10, m10[(base + j - 2) % 1024]);
        chk("rd_data4", rd4, m4[(base + j - 2) % 16]);
      end
      step();
    end
  endtask

  initial begin
    logic [31:0] ra;
    logic [7:0]  rc;
    int          rn;

    rst = 1;
    idle_in();
    step();
    step();
    chk("rst_data10", rd10, 64'd0);
    chk("rst_data4", rd4, 64'd0);
    chk("rst_valid10", rv10, 1'b0);
    chk("rst_valid4", rv4, 1'b0);
    chk("rst_wait10", wt10, 1'b0);
    chk("rst_wait4", wt4, 1'b0);
    rst = 0;
    step();

    // Fill the whole memory; last burst requests 200 beats (clamped).
    for (int k = 0; k < 8; k++) begin
      dq.delete();
      for (int i = 0; i < 128; i++)
        dq.push_back({$urandom, $urandom});
      wr_burst(32'(k * 1024), (k == 7) ? 8'd200 : 8'd128,
               8'hFF, -1, 0);
    end

    // Single write then single read.
    dq = '{64'hDEADBEEF_CAFEF00D};
    wr_burst(32'h40, 8'd1, 8'hFF, -1, 0);
    rd_burst(32'h40, 8'd1);

    // Four-beat burst with a stall after beat 2.
    dq = '{64'd1, 64'd2, 64'd3, 64'd4};
    wr_burst(32'h100, 8'd4, 8'hFF, 2, 0);
    rd_burst(32'h100, 8'd4);

    // Byte enables.
    dq = '{64'hFFFF_FFFF_FFFF_FFFF};
    wr_burst(32'h208, 8'd1, 8'hFF, -1, 0);
    dq = '{64'h0};
    wr_burst(32'h208, 8'd1, 8'h0F, -1, 0);
    rd_burst(32'h208, 8'd1);
    chk("be_model", m10[65], 64'hFFFF_FFFF_0000_0000);

    // Wrap at word 15 (16-word instance) and word 1023 (1024-word).
    dq = '{64'hA15, 64'hA00, 64'hA01};
    wr_burst(32'h78, 8'd3, 8'hFF, -1, 0);
    rd_burst(32'h78, 8'd1);
    rd_burst(32'h00, 8'd1);
    rd_burst(32'h08, 8'd1);
    dq = '{64'hB3FF, 64'hB000, 64'hB001};
    wr_burst(32'h1FF8, 8'd3, 8'hFF, -1, 0);
    rd_burst(32'h1FF8, 8'd1);
    rd_burst(32'h0, 8'd2);

    // Read and write together: write wins, no read data.
    addr = 32'h300; cnt = 8'd1; bb = 1; rd = 1; wr = 1;
    be = 8'hFF; wd = 64'h1234_5678_9ABC_DEF0;
    step();
    model_wr(32'h300 >> 3, 64'h1234_5678_9ABC_DEF0, 8'hFF);
    idle_in();
    for (int j = 0; j < 4; j++) begin
      chk("rw_valid10", rv10, 1'b0);
      chk("rw_valid4", rv4, 1'b0);
      chk_wait_low("rw");
      step();
    end
    rd_burst(32'h300, 8'd1);

    // Clamped long read and zero-count read.
    rd_burst(32'h400, 8'd200);
    rd_burst(32'h18, 8'd0);

    // Reset during beat 2 of an 8-beat read.
    rd = 1; bb = 1; addr = 32'h100; cnt = 8'd8;
    step();
    idle_in();
    step();
    step();
    step();
    chk("pre_rst_valid10", rv10, 1'b1);
    rst = 1;
    #1;
    chk("mid_rst_valid10", rv10, 1'b0);
    chk("mid_rst_valid4", rv4, 1'b0);
    chk("mid_rst_data10", rd10, 64'd0);
    chk_wait_low("mid_rst");
    step();
    step();
    rst = 0;
    step();
    chk_wait_low("post_rst");
    rd_burst(32'h100, 8'd8);

    // Randomized traffic.
    for (int t = 0; t < 30; t++) begin
      ra = $urandom;
      if ($urandom_range(1) == 1) begin
        rn = $urandom_range(1, 6);
        dq.delete();
        for (int i = 0; i < rn; i++)
          dq.push_back({$urandom, $urandom});
        wr_burst(ra, 8'(rn), 8'($urandom), -1, 1);
      end else begin
        rc = 8'($urandom_range(0, 9));
        rd_burst(ra, rc);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
